// File: rtl/joystick_splitter_reader_pkg.sv
// Shared definitions for the joystick splitter reader: frame geometry,
// per-port bit positions and the scan FSM state encoding.
package joystick_splitter_reader_pkg;

  localparam int unsigned JS_FRAME_W = 12;
  localparam int unsigned JS_PORT_W  = 6;

  // Bit positions inside one 6-bit port vector {F2,F1,U,D,L,R}
  localparam int unsigned JS_F2 = 5;
  localparam int unsigned JS_F1 = 4;
  localparam int unsigned JS_U  = 3;
  localparam int unsigned JS_D  = 2;
  localparam int unsigned JS_L  = 1;
  localparam int unsigned JS_R  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLKLO = 3'd2,
    ST_CLKHI = 3'd3,
    ST_DONE  = 3'd4
  } js_state_t;

endpackage

// File: rtl/joysplit_debounce.sv
// Frame acceptance stage for the joystick splitter reader.
// Build option JOYSPLIT_DEBOUNCE_EN: when defined, a frame is accepted only
// if it matches the previous completed frame; otherwise every frame is
// accepted as-is (plain register, no history kept).
module joysplit_debounce
  import joystick_splitter_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [JS_FRAME_W-1:0] frame_in,
  input  logic                  strobe,
  output logic [JS_FRAME_W-1:0] frame_out
);

`ifdef JOYSPLIT_DEBOUNCE_EN
  logic [JS_FRAME_W-1:0] history;

  // Accept a frame only when it repeats the previous completed scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      history   <= '1;
      frame_out <= '1;
    end else if (strobe) begin
      history <= frame_in;
      if (frame_in == history) begin
        frame_out <= frame_in;
      end
    end
  end
`else
  // Every completed frame is accepted directly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_out <= '1;
    end else if (strobe) begin
      frame_out <= frame_in;
    end
  end
`endif

endmodule

// File: rtl/joystick_splitter_reader.sv
// Serial front end for the dual-DB9 joystick splitter board. Periodically
// loads the external PISO chain, clocks out 12 bits MSB-first and presents
// both ports as active-low {F2,F1,U,D,L,R} vectors.
// Build option JOYSPLIT_DEBOUNCE_EN enables two-scan agreement filtering.
module joystick_splitter_reader
  import joystick_splitter_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 8,
  parameter int unsigned SCAN_INTERVAL = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 joy_data,
  output logic                 joy_load_n,
  output logic                 joy_clk,
  output logic [JS_PORT_W-1:0] db9joy1_out,
  output logic [JS_PORT_W-1:0] db9joy2_out,
  output logic                 frame_done
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned INT_W = $clog2(SCAN_INTERVAL);
  localparam int unsigned BIT_W = $clog2(JS_FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(SCAN_INTERVAL - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(JS_FRAME_W - 1);

  js_state_t             state;
  logic [DIV_W-1:0]      div;
  logic [BIT_W-1:0]      bit_cnt;
  logic [INT_W-1:0]      interval;
  logic [1:0]            sync_q;
  logic                  joy_sync;
  logic                  div_last;
  logic [JS_FRAME_W-1:0] frame;
  logic [JS_FRAME_W-1:0] stable_frame;
  logic                  frame_strobe;

  assign joy_sync     = sync_q[1];
  assign div_last     = (div == DIV_LAST);
  assign frame_strobe = (state == ST_DONE);

  // Two-flop synchroniser for the asynchronous chain output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], joy_data};
    end
  end

  // Free-running scan interval counter, 0..SCAN_INTERVAL-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      interval <= '0;
    end else if (interval == INT_LAST) begin
      interval <= '0;
    end else begin
      interval <= interval + INT_W'(1);
    end
  end

  // Scan FSM: load pulse, 12 shift-clock periods, completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      frame      <= '1;
      joy_load_n <= 1'b1;
      joy_clk    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (interval == '0) begin
            state      <= ST_LOAD;
            div        <= '0;
            joy_load_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (div_last) begin
            state      <= ST_CLKLO;
            div        <= '0;
            bit_cnt    <= '0;
            joy_load_n <= 1'b1;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        ST_CLKLO: begin
          if (div_last) begin
            frame   <= {frame[JS_FRAME_W-2:0], joy_sync};
            state   <= ST_CLKHI;
            div     <= '0;
            joy_clk <= 1'b1;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        ST_CLKHI: begin
          if (div_last) begin
            div     <= '0;
            joy_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= ST_CLKLO;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          div        <= '0;
          frame_done <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  joysplit_debounce u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_in  (frame),
    .strobe    (frame_strobe),
    .frame_out (stable_frame)
  );

  assign db9joy1_out = stable_frame[JS_FRAME_W-1:JS_PORT_W];
  assign db9joy2_out = stable_frame[JS_PORT_W-1:0];

endmodule

// File: doc/joystick_splitter_reader.md
# joystick_splitter_reader

Serial front end for the dual-DB9 joystick splitter board. It drives the board's external parallel-in/serial-out shift register chain and deserialises both joystick ports. It presents them as two 6-bit active-low vectors that feed the `db9joy1_in` / `db9joy2_in` inputs of the joystick protocol block. It runs free in the system clock domain and rescans the hardware at a fixed interval.

## Interface
- `CLK_DIV`, 8: system clocks per half period of `joy_clk`; legal range is 4 or more.
- `SCAN_INTERVAL`, 4096: system clocks between scan starts; legal range is 25·CLK_DIV+2 or more.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `joy_data`  in  1  serial data from the chain; asynchronous
- `joy_load_n`  out  1  parallel-load strobe to the chain, active low
- `joy_clk`  out  1  shift clock to the chain; the chain shifts on the rising edge
- `db9joy1_out`  out  6  port 1 as {F2,F1,U,D,L,R}; 0 = pressed
- `db9joy2_out`  out  6  port 2, same format
- `frame_done`  out  1  one-cycle pulse when a scan completes

## Operation
- `joy_data` passes through a 2-flop synchroniser before use. Every sample uses the synchronised value.
- Interval counter:
  - Counts 0..SCAN_INTERVAL-1 and wraps.
  - A scan starts when the count is 0 and the FSM is IDLE.
  - A wrap while the FSM is busy is ignored; the next scan starts at the following wrap.
- FSM states: IDLE, LOAD, CLKLO, CLKHI, DONE. A divider counter `div` runs 0..CLK_DIV-1 and restarts on every state entry.
  - IDLE: `joy_load_n`=1, `joy_clk`=0.
  - LOAD: `joy_load_n`=0, `joy_clk`=0 for CLK_DIV cycles, then go to CLKLO with bit=0.
  - CLKLO: `joy_load_n`=1, `joy_clk`=0 for CLK_DIV cycles. On the last cycle, shift the synchronised `joy_data` into the 12-bit frame register MSB-first.
  - CLKHI: `joy_clk`=1 for CLK_DIV cycles. At the end, go to DONE if bit=11; otherwise increment bit and go to CLKLO.
  - DONE: one cycle, then IDLE.
- Frame bit order (first bit shifted = frame[11]):
  - frame[11:6] = port 1 {F2,F1,U,D,L,R}.
  - frame[5:0] = port 2, same order.
  - A pressed line reads 0.
- Output update happens on the edge leaving DONE, subject to Configuration. `frame_done` pulses on that same edge, for one cycle.
- Reset, including reset mid-scan:
  - FSM to IDLE; interval, divider and bit counters to 0.
  - `joy_load_n`=1, `joy_clk`=0.
  - Both outputs = 6'h3F; `frame_done`=0; frame and debounce history = 12'hFFF.

## Timing
- First LOAD cycle: the first clock after `rst_n` deasserts.
- Scan length, LOAD to DONE inclusive: 25·CLK_DIV+1 cycles.
- Outputs are valid 25·CLK_DIV+1 cycles after scan start.
- Sample point: the last cycle of each CLKLO. Chain data changes only on `joy_clk` rising edges, so with CLK_DIV≥4 the synchroniser lag of 2 cycles stays inside a stable window.
- All outputs are registered; there are no combinational paths from input to output.
- Twelve `joy_clk` rising edges occur per scan. The last one shifts the chain but is not sampled.

## Configuration
- `JOYSPLIT_DEBOUNCE_EN` defined:
  - At DONE the new frame is compared with the previous completed frame.
  - The outputs load only if the two are equal.
  - The new frame always becomes the previous frame.
  - A change in state needs two consecutive identical scans.
- `JOYSPLIT_DEBOUNCE_EN` undefined:
  - The outputs load at every DONE.
  - No history register is built.
- `frame_done` pulses at every DONE in both builds.

## Structure
- Shared package: bit-index constants JS_F2=5, JS_F1=4, JS_U=3, JS_D=2, JS_L=1, JS_R=0; the FSM state encoding; the frame width of 12.
- One sub-module, `joysplit_debounce`: 12-bit frame in, strobe in, 12-bit stable frame out. It is compiled as a pass-through register when `JOYSPLIT_DEBOUNCE_EN` is undefined.

## Test plan
- Reset release, CLK_DIV=4, chain model holds 12'hFFF → LOAD low for 4 cycles; 12 `joy_clk` pulses of 4 high / 4 low; `frame_done` at cycle 101; outputs stay 6'h3F.
- Chain model loads port 1 = 6'b101110 (F1 pressed, R pressed), port 2 = 6'h3F, debounce off → after the first scan, `db9joy1_out`=6'h2E and `db9joy2_out`=6'h3F.
- Debounce on, port 2 pressed U (6'h37) for one scan only, then 6'h3F → `db9joy2_out` stays 6'h3F throughout. Held for two scans → it changes to 6'h37 at the second `frame_done`.
- `rst_n` pulsed low at bit 6 of a scan → next edge gives `joy_load_n`=1, `joy_clk`=0, outputs 6'h3F; a fresh scan starts on the first clock after release.
- SCAN_INTERVAL=110, CLK_DIV=4 → `frame_done` pulses exactly 110 cycles apart, with no overlapping scans.
- `joy_data` toggled asynchronously mid-CLKHI → the sampled bit equals the level present at the end of the following CLKLO.
